// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states,
// default iteration count and a signedness helper.
package mult_div_unit_pkg;

  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_signed_funct(input logic [5:0] f);
    return (f == FUN_MULT) || (f == FUN_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mult_div_unit_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so bit WIDTH of diff is a clean borrow.
  always_comb begin
    shifted  = {rem_in, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[WIDTH];
    rem_out  = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO (radix-2 multiply, restoring divide).
// Define MDU_FAST_MULT_EN for a single-cycle array multiplier on MULT/MULTU.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             div_zero_q, div_zero_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             is_mul, is_div;
  logic [WIDTH-1:0] div_rem;
  logic             div_bit;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    sign_a = is_signed_funct(funct) & opA[WIDTH-1];
    sign_b = is_signed_funct(funct) & opB[WIDTH-1];
    mag_a  = sign_a ? -opA : opA;
    mag_b  = sign_b ? -opB : opB;
    is_mul = (funct == FUN_MULT) || (funct == FUN_MULTU);
    is_div = (funct == FUN_DIV) || (funct == FUN_DIVU);
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_mag;
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    fast_prod = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
  end
`endif

  mult_div_unit_divider #(.WIDTH(WIDTH)) u_divider (
    .rem_in      (acc_hi_q),
    .dividend_bit(acc_lo_q[WIDTH-1]),
    .divisor     (opb_q),
    .rem_out     (div_rem),
    .quot_bit    (div_bit)
  );

  // acc_hi/acc_lo hold {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    div_zero_d = div_zero_q;
    mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    product    = neg_q_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (funct == FUN_MTHI) begin
            hi_d = opA;
          end else if (funct == FUN_MTLO) begin
            lo_d = opA;
          end
`ifdef MDU_FAST_MULT_EN
          else if (is_mul) begin
            {hi_d, lo_d} = fast_prod;
            state_d      = ST_DONE;
          end
`endif
          else if (is_mul || is_div) begin
            state_d    = ST_ITER;
            count_d    = '0;
            is_div_d   = is_div;
            acc_hi_d   = '0;
            acc_lo_d   = is_div ? mag_a : mag_b;
            opb_d      = is_div ? mag_b : mag_a;
            neg_q_d    = sign_a ^ sign_b;
            neg_r_d    = sign_a;
            div_zero_d = (opB == '0);
          end
        end
      end
      ST_ITER: begin
        count_d = count_q + CW'(1);
        if (is_div_q) begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_bit};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end
        if (flush) begin
          state_d = ST_IDLE;
        end else if (count_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (is_div_q) begin
            lo_d = div_zero_q ? '1 : (neg_q_q ? -acc_lo_q : acc_lo_q);
            hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
          end else begin
            {hi_d, lo_d} = product;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    busy = (state_q == ST_ITER) || (state_q == ST_FIX);
    done = (state_q == ST_DONE);
    hi   = hi_q;
    lo   = lo_q;
    if (funct == FUN_MFHI) begin
      out = hi_q;
    end else if (funct == FUN_MFLO) begin
      out = lo_q;
    end else begin
      out = '0;
    end
  end

endmodule
